mips_fetch_stage: RTL and testbench

- IF stage of the MIPS pipeline. Owns the program counter and computes next-PC (sequential, branch, jump).
- Drives the address and enable of the byte-addressed, big-endian instruction memory, which returns the instruction combinationally in the same cycle.
- Registers the returned instruction into the IF/ID pipeline register consumed by decode.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_next_pc.sv | 39 +++
 rtl/mips_fetch_stage.sv | 113 +++++++++++
 tb/tb_mips_fetch_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS pipeline slice.
//   word_t    - 32-bit machine word
//   ifid_t    - IF/ID pipeline register contents (instr, pc_plus4, valid)
//   NOP_INSTR - encoding inserted as a bubble (sll $0,$0,0)
//   PC_INCR   - sequential PC increment in bytes
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;
    localparam word_t PC_INCR   = 32'd4;

    typedef struct packed {
        word_t instr;
        word_t pc_plus4;
        logic  valid;
    } ifid_t;

endpackage

// File: rtl/mips_next_pc.sv
// mips_next_pc: combinational next-PC priority mux.
//   pc            in  current PC
//   stall         in  hold request from the hazard unit
//   branch_taken  in  branch resolved taken (highest priority)
//   branch_target in  branch destination
//   jump          in  jump decoded (below branch)
//   jump_target   in  jump destination
//   pc_plus4      out pc + 4, modulo 2^32
//   next_pc       out value the PC register loads on the next edge
module mips_next_pc
    import mips_pkg::*;
(
    input  word_t pc,
    input  logic  stall,
    input  logic  branch_taken,
    input  word_t branch_target,
    input  logic  jump,
    input  word_t jump_target,
    output word_t pc_plus4,
    output word_t next_pc
);

    // Plain 32-bit add: 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc + PC_INCR;

    // A redirect comes from an instruction older than the stalled one,
    // so it wins over stall; branch wins over jump.
    always_comb begin
        next_pc = pc_plus4;
        if (branch_taken) begin
            next_pc = branch_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (stall) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: IF stage. Owns the PC, drives the instruction memory
// (combinational read, same cycle) and registers the fetched word into IF/ID.
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   stall             hold PC and IF/ID (a redirect still moves the PC)
//   flush             replace IF/ID contents with a bubble
//   branch_taken/_target, jump/jump_target   PC redirects
//   imem_pc, imem_en  memory address (= PC) and read enable
//   imem_instr        word returned by memory for imem_pc
//   ifid_instr/_pc_plus4/_valid  IF/ID register towards decode
//   fetch_fault       sticky bad-fetch flag, present only when the macro
//                     FETCH_ALIGN_CHECK_EN is defined
// Pipeline control: IF/ID is a plain register with no backpressure handshake.
// stall freezes it, flush/redirect empties it, otherwise it loads every cycle.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter word_t RESET_PC   = 32'h0000_0000,
    parameter int    IMEM_BYTES = 2048
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall,
    input  logic  flush,
    input  logic  branch_taken,
    input  word_t branch_target,
    input  logic  jump,
    input  word_t jump_target,
    output word_t imem_pc,
    output logic  imem_en,
    input  word_t imem_instr,
    output word_t ifid_instr,
    output word_t ifid_pc_plus4,
    output logic  ifid_valid
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic  fetch_fault
`endif
);

    word_t pc;
    word_t pc_plus4;
    word_t next_pc;
    ifid_t ifid_q;
    ifid_t ifid_d;
    logic  fetch_bad;

    mips_next_pc u_next_pc (
        .pc            (pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    assign imem_pc = pc;
    assign imem_en = rst_n & ~stall;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam word_t PC_MAX = word_t'(IMEM_BYTES - 4);

    logic fault_q;

    // Only an actual (unstalled) fetch can fault.
    assign fetch_bad   = ~stall & ((pc[1:0] != 2'b00) | (pc > PC_MAX));
    assign fetch_fault = fault_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (fetch_bad) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign fetch_bad = 1'b0;
`endif

    always_comb begin
        ifid_d = ifid_q;
        if (flush | branch_taken | jump) begin
            // Bubble; pc_plus4 is left as-is since decode ignores it.
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
        end else if (!stall) begin
            ifid_d.pc_plus4 = pc_plus4;
            if (fetch_bad) begin
                ifid_d.instr = NOP_INSTR;
                ifid_d.valid = 1'b0;
            end else begin
                ifid_d.instr = imem_instr;
                ifid_d.valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            ifid_q <= '{instr: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};
        end else begin
            pc     <= next_pc;
            ifid_q <= ifid_d;
        end
    end

    assign ifid_instr    = ifid_q.instr;
    assign ifid_pc_plus4 = ifid_q.pc_plus4;
    assign ifid_valid    = ifid_q.valid;

endmodule

// File: tb/tb_mips_fetch_stage.sv
module tb_mips_fetch_stage;
    import mips_pkg::*;

    localparam word_t RESET_PC   = 32'h0000_0000;
    localparam int    IMEM_BYTES = 2048;
    localparam word_t PC_MAX     = word_t'(IMEM_BYTES - 4);

    // ---------------- clock / reset / DUT ----------------
    logic  clk = 1'b0;
    logic  rst_n, stall, flush, branch_taken, jump;
    word_t branch_target, jump_target;
    word_t imem_pc, imem_instr, ifid_instr, ifid_pc_plus4;
    logic  imem_en, ifid_valid;
    logic  fetch_fault_w;

    always #5 clk = ~clk;

    mips_fetch_stage #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_pc       (imem_pc),
        .imem_en       (imem_en),
        .imem_instr    (imem_instr),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault   (fetch_fault_w)
`endif
    );

`ifndef FETCH_ALIGN_CHECK_EN
    assign fetch_fault_w = 1'b0;
`endif

    // Instruction memory model: address-dependent pattern, word 0 fixed.
    function automatic word_t mem_word(input word_t a);
        if (a == 32'd0) return 32'h2008_0005;
        return {a[15:0] ^ 16'h3C00, a[15:0]};
    endfunction

    assign imem_instr = mem_word(imem_pc);

    // ---------------- scoreboard ----------------
    // entry = {fault, instr, pc_plus4, valid}
    logic [65:0] exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    word_t m_pc;
    ifid_t m_if;
    logic  m_fault;
    logic  m_known = 1'b0;

    task automatic check(input string tag, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic s, input logic f,
                        input logic b, input word_t bt,
                        input logic j, input word_t jt);
        word_t n_pc, p4;
        ifid_t n_if;
        logic  n_fault, bad;
        logic [65:0] e;
        rst_n = r; stall = s; flush = f;
        branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
        #1;
        if (m_known) begin
            check("imem_pc", imem_pc, m_pc);
            check("imem_en", {31'd0, imem_en}, {31'd0, r & ~s});
        end
        // spec model of next state
        p4  = m_pc + 32'd4;
        bad = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        bad = ~s && ((m_pc[1:0] != 2'b00) || (m_pc > PC_MAX));
`endif
        if (!r) begin
            n_pc = RESET_PC; n_if = '{32'd0, 32'd0, 1'b0}; n_fault = 1'b0;
        end else begin
            n_pc    = b ? bt : (j ? jt : (s ? m_pc : p4));
            n_fault = m_fault | bad;
            if (f || b || j)  n_if = '{32'd0, m_if.pc_plus4, 1'b0};
            else if (s)       n_if = m_if;
            else if (bad)     n_if = '{32'd0, p4, 1'b0};
            else              n_if = '{mem_word(m_pc), p4, 1'b1};
        end
        exp_q.push_back({n_fault, n_if.instr, n_if.pc_plus4, n_if.valid});
        @(posedge clk);
        #1;
        m_pc = n_pc; m_if = n_if; m_fault = n_fault; m_known = 1'b1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("ifid_instr", ifid_instr, e[64:33]);
            check("ifid_pc_plus4", ifid_pc_plus4, e[32:1]);
            check("ifid_valid", {31'd0, ifid_valid}, {31'd0, e[0]});
`ifdef FETCH_ALIGN_CHECK_EN
            check("fetch_fault", {31'd0, fetch_fault_w}, {31'd0, e[65]});
`endif
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
        m_pc = RESET_PC; m_if = '{32'd0, 32'd0, 1'b0}; m_fault = 1'b0;
        @(negedge clk);

        // reset for 3 cycles, then fetch from RESET_PC
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        check("pc_after_reset", imem_pc, RESET_PC);
        step(1, 0, 0, 0, 0, 0, 0);
        check("first_instr", ifid_instr, 32'h2008_0005);
        check("first_pc4", ifid_pc_plus4, 32'd4);

        // sequential fetch
        run(7);

        // move to 0x10, stall 3 cycles, resume
        step(1, 0, 0, 0, 0, 1, 32'h10);
        run(1);
        check("pc_before_stall", imem_pc, 32'h14);
        step(1, 0, 0, 0, 0, 1, 32'h10);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
        check("pc_held", imem_pc, 32'h10);
        run(2);

        // redirect beats stall; branch beats jump
        step(1, 1, 0, 1, 32'h40, 1, 32'h80);
        check("redirect_pc", imem_pc, 32'h40);
        run(2);

        // flush alone, then PC wrap
        step(1, 0, 1, 0, 0, 0, 0);
        run(1);
        step(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        run(1);
        check("wrap_pc", imem_pc, 32'd0);
        run(1);

        // reset mid-stream, with stall raised on release
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        run(3);

        // random mix
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 29) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0),
                 {20'd0, 10'($urandom_range(0, 511)), 2'b00},
                 ($urandom_range(0, 9) == 0),
                 {20'd0, 10'($urandom_range(0, 511)), 2'b00});
        end

`ifdef FETCH_ALIGN_CHECK_EN
        // misaligned branch target: sticky fault
        step(0, 0, 0, 0, 0, 0, 0);
        run(2);
        check("fault_clear", {31'd0, fetch_fault_w}, 32'd0);
        step(1, 0, 0, 1, 32'h42, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("fault_set", {31'd0, fetch_fault_w}, 32'd1);
        check("fault_bubble", {31'd0, ifid_valid}, 32'd0);
        run(10);
        check("fault_sticky", {31'd0, fetch_fault_w}, 32'd1);
`endif

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
